icache_assoc_param: RTL
=======================

// Module: icache_assoc_param
// PURPOSE
//   Parametrised set-associative, read-only instruction cache for the fetch stage.
//   Next generation of the 2-way I-cache: configurable ways, sets and block size; all ways compared in parallel.
//   Hits return in the same cycle. Tree pseudo-LRU replacement. Whole-cache flush.
//   Sits between the PC register / fetch logic and the memory arbiter; refills whole blocks from main memory.
// PARAMETERS
//   WAYS         2    associativity; legal values 1, 2, 4
//   SETS         64   number of sets; power of 2, 2..256
//   BLOCK_WORDS  8    16-bit words per block; power of 2, 2..16
//   ADDR_W       16   byte-address width; word = 2 bytes, so addr[0] is ignored
// PORTS
//   clk             in   1       clock; all state changes on the rising edge
//   rst             in   1       synchronous, active-high reset
//   addr            in   ADDR_W  fetch byte address (the PC)
//   rd_en           in   1       fetch request this cycle
//   instr           out  16      fetched instruction; 16'h7000 (NOP) whenever hit=0
//   hit             out  1       instr valid this cycle
//   stall           out  1       fetch must hold the PC: (rd_en & ~hit) | state!=LOOKUP
//   flush           in   1       start invalidation of all lines (single-cycle pulse)
//   flush_busy      out  1       high while the FLUSH state is active
//   mem_req         out  1       word-read request to the arbiter
//   mem_grant       in   1       arbiter accepts mem_req this cycle
//   mem_addr        out  ADDR_W  byte address of the requested word
//   mem_data        in   16      returned word
//   mem_data_valid  in   1       mem_data valid; words return in request order
// BEHAVIOUR
//   Address split: off=addr[log2(BLOCK_WORDS):1], idx=next log2(SETS) bits, tag=remaining upper bits.
//   Per line: valid bit, tag. Per set: WAYS-1 PLRU bits.
//   Reset: state=LOOKUP. All valid bits and PLRU bits cleared.
//     Outputs at reset: hit=0, stall=0, mem_req=0, mem_addr=0, flush_busy=0, instr=16'h7000.
//   LOOKUP:
//     - rd_en & hit in any way: hit=1, instr=data[way][idx][off] combinationally (0-cycle latency).
//       The set's PLRU is updated at the clock edge to point away from the hit way.
//     - rd_en & miss: stall=1.
//       Latch block base address, idx, tag.
//       Latch the victim: first invalid way (lowest number); if none, the PLRU-selected way.
//       Go to FILL.
//     - flush (priority over rd_en): go to FLUSH.
//   FILL:
//     - Request counter rq (0..BLOCK_WORDS): mem_req=1 while rq<BLOCK_WORDS; mem_addr=base+2*rq.
//       rq increments on mem_req & mem_grant.
//     - Response counter rs: each mem_data_valid writes mem_data into victim word rs, then rs increments.
//       Responses before a grant cannot occur; the arbiter guarantees this.
//     - On the last response: set valid, write tag, update PLRU toward the victim; go to LOOKUP.
//       The replay hits in the next cycle if addr is unchanged.
//     - flush during FILL: recorded in a pending bit; honoured on return to LOOKUP.
//       The fill is never abandoned. Memory has no cancel.
//   FLUSH:
//     - Clears valid and PLRU for one set per cycle, idx 0..SETS-1.
//     - flush_busy=1 and stall=1 for exactly SETS cycles; then back to LOOKUP.
//     - A flush pulse received in FLUSH is ignored.
//   Miss penalty: 1 + grant wait + memory latency + BLOCK_WORDS-1 + 1 replay cycle.
//   Address wrap: a block never spans sets. mem_addr wraps modulo 2^ADDR_W.
//   WAYS=1: no PLRU bits; the victim is always way 0.
//   rst mid-FILL or mid-FLUSH: immediately LOOKUP, all lines invalid, mem_req=0.
//     Any late mem_data_valid after reset is ignored.
//   rd_en=0 in LOOKUP: no PLRU or state change; hit=0, stall=0.
// TESTING
//   1. Cold miss, addr=16'h0010, memory latency 3, grant always 1:
//      mem_addr 0x10,0x12..0x1E on consecutive cycles; stall high until replay; then hit=1, instr=mem[0x10].
//   2. Sequential fetch 0x12..0x1E after test 1: hit=1 every cycle, mem_req never asserted.
//   3. WAYS=2, three tags on idx 1 (0x0010, 0x0410, 0x0810), then re-access 0x0410:
//      0x0010 (LRU) evicted; 0x0410 hits; 0x0010 misses again.
//   4. WAYS=4: fill 4 tags in set 0, touch ways 0,2; next miss evicts the PLRU way.
//      Bench model predicts way 1; check with mem_req count = BLOCK_WORDS.
//   5. flush pulse mid-FILL: fill completes; FLUSH follows with flush_busy=1 for exactly SETS cycles;
//      the previous hit address then misses.
//   6. rst asserted on the 3rd fill word, then mem_data_valid keeps arriving:
//      no array writes, mem_req=0, subsequent fetch of 0x0010 misses.

Source files
------------

// File: rtl/icache_assoc_param.sv
// Set-associative read-only instruction cache with tree pseudo-LRU and whole-cache flush.
// Latency: hits return combinationally in the same cycle; a miss refills the block word by word.
// Backpressure: stall holds the PC while a miss, fill or flush is in progress; mem_req waits for mem_grant.
module icache_assoc_param #(
  parameter int WAYS        = 2,
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  output logic [15:0]       instr,
  output logic              hit,
  output logic              stall,
  input  logic              flush,
  output logic              flush_busy,
  output logic              mem_req,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_data_valid
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PL_W  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [15:0] NOP = 16'h7000;

  typedef enum logic [1:0] {LOOKUP, FILL, FLUSH} state_t;

  // Tree PLRU: bit 0 is the root (1 = victim in upper half); bits 1/2 pick within lower/upper pair.
  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] p, input logic [WAY_W-1:0] w);
    logic [PL_W-1:0] n;
    n = p;
    if (WAYS == 2) begin
      n[0] = ~w[0];
    end else if (WAYS == 4) begin
      n[0] = ~w[WAY_W-1];
      if (w[WAY_W-1]) n[PL_W-1] = ~w[0];
      else            n[PL_W/2] = ~w[0];
    end
    return n;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] p);
    logic [WAY_W-1:0] v;
    v = '0;
    if (WAYS == 2) begin
      v[0] = p[0];
    end else if (WAYS == 4) begin
      v[WAY_W-1] = p[0];
      v[0]       = p[0] ? p[PL_W-1] : p[PL_W/2];
    end
    return v;
  endfunction

  // Address fields of the current fetch
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [ADDR_W-1:0] blk_base;
  logic              unused_addr_bit;

  assign off             = addr[OFF_W:1];
  assign idx             = addr[OFF_W+IDX_W:OFF_W+1];
  assign tag             = addr[ADDR_W-1:OFF_W+IDX_W+1];
  assign blk_base        = {addr[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
  assign unused_addr_bit = addr[0];

  // Storage
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [15:0]      data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [PL_W-1:0]  plru_q  [SETS];

  // Control state
  state_t            state_q;
  logic [CNT_W-1:0]  rq_q;
  logic [CNT_W-1:0]  rs_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  fill_idx_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [WAY_W-1:0]  victim_q;
  logic              flush_pend_q;
  logic [IDX_W-1:0]  flush_cnt_q;

  logic [WAYS-1:0]   way_hit;
  logic              any_hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  victim_sel;
  logic              flush_now;
  logic              fill_wr;
  logic              fill_last;

  // Parallel tag compare across all ways; lowest matching way wins
  always_comb begin
    way_hit = '0;
    any_hit = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_hit[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
      if (way_hit[w]) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest invalid way, otherwise the PLRU pick
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_sel = inv_found ? inv_way : plru_victim(plru_q[idx]);
  end

  // A pending or fresh flush pre-empts the fetch in LOOKUP
  assign flush_now  = flush | flush_pend_q;
  assign hit        = (state_q == LOOKUP) && rd_en && any_hit && !flush_now;
  assign instr      = hit ? data_q[hit_way][idx][off] : NOP;
  assign stall      = (rd_en && !hit) || (state_q != LOOKUP);
  assign flush_busy = (state_q == FLUSH);
  assign mem_req    = (state_q == FILL) && (rq_q < CNT_W'(BLOCK_WORDS));
  assign mem_addr   = mem_req ? base_q + ADDR_W'({rq_q, 1'b0}) : '0;
  assign fill_wr    = (state_q == FILL) && mem_data_valid;
  assign fill_last  = fill_wr && (rs_q == CNT_W'(BLOCK_WORDS - 1));

  // Main FSM: lookup/refill/flush sequencing plus valid and PLRU state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOOKUP;
      rq_q         <= '0;
      rs_q         <= '0;
      base_q       <= '0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        LOOKUP: begin
          if (flush_now) begin
            state_q      <= FLUSH;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
          end else if (rd_en) begin
            if (any_hit) begin
              plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            end else begin
              base_q     <= blk_base;
              fill_idx_q <= idx;
              fill_tag_q <= tag;
              victim_q   <= victim_sel;
              rq_q       <= '0;
              rs_q       <= '0;
              state_q    <= FILL;
            end
          end
        end
        FILL: begin
          // Memory cannot cancel, so a flush here only waits for the fill to finish
          if (flush) flush_pend_q <= 1'b1;
          if (mem_req && mem_grant) rq_q <= rq_q + 1'b1;
          if (fill_wr) rs_q <= rs_q + 1'b1;
          if (fill_last) begin
            valid_q[fill_idx_q][victim_q] <= 1'b1;
            plru_q[fill_idx_q]            <= plru_touch(plru_q[fill_idx_q], victim_q);
            state_q                       <= LOOKUP;
          end
        end
        FLUSH: begin
          valid_q[flush_cnt_q] <= '0;
          plru_q[flush_cnt_q]  <= '0;
          flush_cnt_q          <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == IDX_W'(SETS - 1)) state_q <= LOOKUP;
        end
        default: state_q <= LOOKUP;
      endcase
    end
  end

  // Data and tag arrays need no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (!rst && fill_wr) data_q[victim_q][fill_idx_q][rs_q[OFF_W-1:0]] <= mem_data;
    if (!rst && fill_last) tag_q[victim_q][fill_idx_q] <= fill_tag_q;
  end

endmodule
